// File: rtl/comparator_bist_if.sv
// Signal bundle between the comparator BIST controller (master) and the
// comparator under test plus its supervisor (slave).
interface comparator_bist_if;
  logic       start;
  logic [3:0] a_o;
  logic [3:0] b_o;
  logic       eq_i;
  logic       gt_i;
  logic       sm_i;
  logic       busy;
  logic       done;
  logic       pass;
  logic [8:0] err_cnt;
  logic [3:0] fail_a;
  logic [3:0] fail_b;

  modport master (
    input  start, eq_i, gt_i, sm_i,
    output a_o, b_o, busy, done, pass, err_cnt, fail_a, fail_b
  );

  modport slave (
    output start, eq_i, gt_i, sm_i,
    input  a_o, b_o, busy, done, pass, err_cnt, fail_a, fail_b
  );
endinterface

// File: rtl/comparator_bist.sv
// Exhaustive 4-bit comparator self-test: sweeps all 256 (A,B) pairs and logs mismatches.
// Optional feature: define COMPARATOR_BIST_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module comparator_bist #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  comparator_bist_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [8:0] ERR_MAX   = 9'd256;

  state_t     state_q;
  logic [7:0] index_q;
  logic [3:0] settle_q;
  logic [8:0] err_cnt_q;
  logic [3:0] fail_a_q;
  logic [3:0] fail_b_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;

  logic [3:0] a_d;
  logic [3:0] b_d;
  logic [2:0] exp_flags;
  logic [2:0] got_flags;
  logic       mismatch;
  logic       stop_early;
  logic [8:0] err_cnt_d;

  function automatic logic [8:0] sat_inc(input logic [8:0] v);
    return (v >= ERR_MAX) ? ERR_MAX : v + 9'd1;
  endfunction

  assign a_d       = index_q[7:4];
  assign b_d       = index_q[3:0];
  assign exp_flags = {a_d == b_d, a_d > b_d, a_d < b_d};
  assign got_flags = {bus.eq_i, bus.gt_i, bus.sm_i};
  assign mismatch  = (exp_flags != got_flags);
  assign err_cnt_d = mismatch ? sat_inc(err_cnt_q) : err_cnt_q;

`ifdef COMPARATOR_BIST_STOP_ON_FAIL_EN
  assign stop_early = mismatch;
`else
  assign stop_early = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      index_q   <= 8'd0;
      settle_q  <= 4'd0;
      err_cnt_q <= 9'd0;
      fail_a_q  <= 4'd0;
      fail_b_q  <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q   <= S_WAIT;
            index_q   <= 8'd0;
            settle_q  <= SETTLE_LD;
            err_cnt_q <= 9'd0;
            fail_a_q  <= 4'd0;
            fail_b_q  <= 4'd0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
          end
        end
        S_WAIT: begin
          // Counter is loaded with SETTLE_CYCLES, so leaving at 1 gives exactly that many WAIT cycles.
          settle_q <= settle_q - 4'd1;
          if (settle_q <= 4'd1) begin
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          err_cnt_q <= err_cnt_d;
          if (mismatch && (err_cnt_q == 9'd0)) begin
            fail_a_q <= a_d;
            fail_b_q <= b_d;
          end
          if ((index_q == 8'hFF) || stop_early) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == 9'd0);
          end else begin
            state_q  <= S_WAIT;
            index_q  <= index_q + 8'd1;
            settle_q <= SETTLE_LD;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a_o     = a_d;
  assign bus.b_o     = b_d;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.err_cnt = err_cnt_q;
  assign bus.fail_a  = fail_a_q;
  assign bus.fail_b  = fail_b_q;

endmodule

// File: tb/tb_comparator_bist.sv
// Bench for comparator_bist: emulated comparators (good, swapped, stuck, random faults)
// checked against a table-driven reference of sweep outcome and timing.
module tb_comparator_bist;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  comparator_bist_if if1();
  comparator_bist_if if15();

  comparator_bist #(.SETTLE_CYCLES(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(if1.master));
  comparator_bist #(.SETTLE_CYCLES(15)) u_dut15 (.clk(clk), .rst_n(rst_n), .bus(if15.master));

  // Response of the emulated comparator under test, indexed by {A,B}; bits are {eq,gt,sm}.
  logic [2:0] resp_tbl [256];

  assign if1.eq_i  = resp_tbl[{if1.a_o, if1.b_o}][2];
  assign if1.gt_i  = resp_tbl[{if1.a_o, if1.b_o}][1];
  assign if1.sm_i  = resp_tbl[{if1.a_o, if1.b_o}][0];
  assign if15.eq_i = resp_tbl[{if15.a_o, if15.b_o}][2];
  assign if15.gt_i = resp_tbl[{if15.a_o, if15.b_o}][1];
  assign if15.sm_i = resp_tbl[{if15.a_o, if15.b_o}][0];

  logic       sel15 = 1'b0;
  logic       m_busy, m_done, m_pass;
  logic [8:0] m_err;
  logic [3:0] m_a, m_b, m_fa, m_fb;

  assign m_busy = sel15 ? if15.busy    : if1.busy;
  assign m_done = sel15 ? if15.done    : if1.done;
  assign m_pass = sel15 ? if15.pass    : if1.pass;
  assign m_err  = sel15 ? if15.err_cnt : if1.err_cnt;
  assign m_a    = sel15 ? if15.a_o     : if1.a_o;
  assign m_b    = sel15 ? if15.b_o     : if1.b_o;
  assign m_fa   = sel15 ? if15.fail_a  : if1.fail_a;
  assign m_fb   = sel15 ? if15.fail_b  : if1.fail_b;

  function automatic logic [2:0] ideal(input int i);
    int a, b;
    a = i / 16;
    b = i % 16;
    return {a == b, a > b, a < b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel15) if15.start = v;
    else       if1.start  = v;
  endtask

  // 0 good, 1 gt/sm swapped, 2 eq stuck at 0, 3 random sparse faults, 4 all flags low
  task automatic load_tbl(input int mode);
    for (int i = 0; i < 256; i++) begin
      logic [2:0] g;
      g = ideal(i);
      case (mode)
        1:       resp_tbl[i] = {g[2], g[0], g[1]};
        2:       resp_tbl[i] = {1'b0, g[1], g[0]};
        3:       resp_tbl[i] = ($urandom_range(0, 11) == 0) ? (g ^ 3'($urandom_range(1, 7))) : g;
        4:       resp_tbl[i] = 3'b000;
        default: resp_tbl[i] = g;
      endcase
    end
  endtask

  // Launch a sweep, follow it to done and compare outcome with the reference.
  task automatic run_sweep(input string tag, input int s, input int poke);
    int exp_err, first, exp_lat, last_idx, lat, trk_bad, idx;
    bit stop_en;
`ifdef COMPARATOR_BIST_STOP_ON_FAIL_EN
    stop_en = 1'b1;
`else
    stop_en = 1'b0;
`endif
    exp_err = 0;
    first   = -1;
    for (int i = 0; i < 256; i++) begin
      if (resp_tbl[i] !== ideal(i)) begin
        exp_err++;
        if (first < 0) first = i;
      end
    end
    if (stop_en && first >= 0) begin
      exp_err  = 1;
      exp_lat  = (first + 1) * (s + 1);
      last_idx = first;
    end else begin
      exp_lat  = 256 * (s + 1);
      last_idx = 255;
    end

    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    chk({tag, "_busy_on_start"}, 32'(m_busy), 32'd1);
    chk({tag, "_done_low_on_start"}, 32'(m_done), 32'd0);
    chk({tag, "_err_cleared"}, 32'(m_err), 32'd0);

    lat = 0;
    trk_bad = 0;
    for (int n = 1; n <= exp_lat + 20; n++) begin
      if (n == poke) set_start(1'b1);
      @(posedge clk); #1;
      if (n == poke) set_start(1'b0);
      if (m_done) begin
        lat = n;
        break;
      end
      idx = n / (s + 1);
      if ({m_a, m_b} !== idx[7:0] || m_busy !== 1'b1 || m_pass !== 1'b0) trk_bad++;
    end

    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_vector_track"}, 32'(trk_bad), 32'd0);
    chk({tag, "_err_cnt"}, 32'(m_err), 32'(exp_err));
    chk({tag, "_pass"}, 32'(m_pass), 32'(exp_err == 0));
    chk({tag, "_fail_a"}, 32'(m_fa), (first < 0) ? 32'd0 : 32'(first / 16));
    chk({tag, "_fail_b"}, 32'(m_fb), (first < 0) ? 32'd0 : 32'(first % 16));
    chk({tag, "_busy_at_done"}, 32'(m_busy), 32'd0);
    chk({tag, "_last_vector"}, 32'({m_a, m_b}), 32'(last_idx));
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_held"}, 32'(m_done), 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    if1.start  = 1'b0;
    if15.start = 1'b0;
    load_tbl(0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a", 32'(if1.a_o), 32'd0);
    chk("rst_b", 32'(if1.b_o), 32'd0);
    chk("rst_busy_done_pass", 32'({if1.busy, if1.done, if1.pass}), 32'd0);
    chk("rst_err_fail", 32'({if1.err_cnt, if1.fail_a, if1.fail_b}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_no_busy", 32'(if1.busy), 32'd0);

    // Good comparator; a start pulse mid-sweep must not disturb timing.
    run_sweep("good", 1, 50);
    load_tbl(1);
    run_sweep("swapped", 1, 0);
    load_tbl(2);
    run_sweep("eq_stuck0", 1, 0);
    for (int r = 0; r < 3; r++) begin
      load_tbl(3);
      run_sweep($sformatf("rand%0d", r), 1, 0);
    end
    load_tbl(4);
    run_sweep("all_wrong", 1, 0);

    // Reset mid-sweep with a faulty comparator so counters are non-zero when hit.
    load_tbl(1);
    if1.start = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    chk("pre_abort_busy", 32'(if1.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_a_b", 32'({if1.a_o, if1.b_o}), 32'd0);
    chk("abort_flags", 32'({if1.busy, if1.done, if1.pass}), 32'd0);
    chk("abort_err_fail", 32'({if1.err_cnt, if1.fail_a, if1.fail_b}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_abort_idle", 32'({if1.busy, if1.done}), 32'd0);
    load_tbl(0);
    run_sweep("after_abort", 1, 30);

    // Long settle time on the second instance.
    sel15 = 1'b1;
    run_sweep("settle15", 15, 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/comparator_bist.md
COMPARATOR_BIST -- requirements
Module: comparator_bist

Interface
REQ-001 The block SHALL have one parameter: SETTLE_CYCLES, default 1, number of cycles a vector is held before the response is sampled (legal range 1..15).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with ports as below (clock and reset first):
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a sweep.
- a_o  output  4  operand A driven to the comparator under test.
- b_o  output  4  operand B driven to the comparator under test.
- eq_i  input  1  DUT equal flag.
- gt_i  input  1  DUT A-greater flag.
- sm_i  input  1  DUT A-smaller flag.
- busy  output  1  sweep in progress.
- done  output  1  sweep finished; held until the next start or reset.
- pass  output  1  valid with done; 1 when err_cnt is 0.
- err_cnt  output  9  number of mismatching vectors (0..256).
- fail_a  output  4  A of the first mismatching vector.
- fail_b  output  4  B of the first mismatching vector.

Function
REQ-003 The FSM SHALL have three states: IDLE, WAIT, CHECK, plus a terminal state DONE.
REQ-004 start sampled high in IDLE or DONE SHALL clear err_cnt, fail_a, fail_b, done and pass, set index to 0 (a_o=0, b_o=0), load the settle counter with SETTLE_CYCLES, assert busy and enter WAIT.
REQ-005 start SHALL be ignored while busy is 1.
REQ-006 WAIT SHALL hold a_o/b_o stable and decrement the settle counter, moving to CHECK when it reaches 0; WAIT lasts exactly SETTLE_CYCLES cycles.
REQ-007 CHECK SHALL last one cycle and compare {eq_i,gt_i,sm_i} against the expected value {a_o==b_o, a_o>b_o, a_o<b_o} (unsigned).
REQ-008 Any bit difference in CHECK SHALL count as one mismatch and increment err_cnt by 1.
REQ-009 On the first mismatch of a sweep (err_cnt was 0), fail_a/fail_b SHALL capture a_o/b_o; later mismatches SHALL NOT overwrite them.
REQ-010 The 8-bit vector index SHALL map as a_o=index[7:4], b_o=index[3:0], sweeping all 256 pairs in ascending index order.
REQ-011 From CHECK with index<255, the block SHALL increment index, reload the settle counter and return to WAIT; with index==255 it SHALL enter DONE without wrapping the index.
REQ-012 In DONE: busy=0, done=1, pass=(err_cnt==0); a_o/b_o hold the last vector.
REQ-013 done SHALL rise exactly 256*(SETTLE_CYCLES+1) cycles after the clock edge that sampled start (512 for the default).
REQ-014 err_cnt SHALL never wrap; 256 is reachable and is the maximum.
REQ-015 start in DONE SHALL restart per REQ-004, with done deasserting on the same edge that asserts busy.

Reset
REQ-016 rst_n low SHALL immediately force IDLE and set a_o, b_o, err_cnt, fail_a, fail_b, busy, done and pass to 0, independent of clk.
REQ-017 Reset asserted mid-sweep SHALL abort the sweep; after release, the block SHALL wait in IDLE for a new start.

Configuration
REQ-018 Macro COMPARATOR_BIST_STOP_ON_FAIL_EN defined: the first mismatch in CHECK SHALL enter DONE on the next edge with err_cnt=1, pass=0, and fail_a/fail_b captured.
REQ-019 Macro undefined: the full 256-vector sweep SHALL always complete, per REQ-011.

Verification
REQ-020 Correct comparator, SETTLE_CYCLES=1, start pulse -> done at +512 cycles, pass=1, err_cnt=0, fail_a=0, fail_b=0.
REQ-021 DUT with gt/sm swapped, macro undefined -> err_cnt=240, pass=0, fail_a=0, fail_b=1.
REQ-022 DUT with eq_i stuck at 0 -> err_cnt=16, fail_a=0, fail_b=0.
REQ-023 Macro defined, gt/sm swapped, SETTLE_CYCLES=1 -> done at +4 cycles, err_cnt=1, fail_a=0, fail_b=1.
REQ-024 rst_n pulsed low at cycle 100 of a sweep -> all outputs 0 asynchronously; start pulses during busy have no effect; a later start completes a normal sweep.
REQ-025 SETTLE_CYCLES=15, correct DUT -> done at +4096 cycles, a_o/b_o stable across every WAIT, pass=1.
